vm_host: RTL and testbench

VM_HOST -- requirements
Module: vm_host

---
 rtl/vm_pkg.sv | 32 +++
 rtl/vm_host_if.sv | 44 ++++
 rtl/vm_host_collect.sv | 79 +++++++
 rtl/vm_host.sv | 133 +++++++++++++
 tb/tb_vm_host.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vm_pkg.sv
// Shared vending-machine host definitions: command ops, FSM states, item count, coin values.
// change_sum() is only referenced when VM_HOST_CHANGE_SUM_EN is defined.
package vm_pkg;
  localparam int NUM_ITEMS = 6;

  localparam logic [1:0] OP_LOAD_PRICES = 2'd0;
  localparam logic [1:0] OP_COIN        = 2'd1;
  localparam logic [1:0] OP_BUY         = 2'd2;
  localparam logic [1:0] OP_REFUND      = 2'd3;

  typedef logic [2:0] state_t;
  localparam state_t S_IDLE    = 3'd0;
  localparam state_t S_PRICE   = 3'd1;
  localparam state_t S_COIN    = 3'd2;
  localparam state_t S_CMD     = 3'd3;
  localparam state_t S_WAIT    = 3'd4;
  localparam state_t S_COLLECT = 3'd5;
  localparam state_t S_RESP    = 3'd6;

  localparam logic [10:0] COIN_50 = 11'd50;
  localparam logic [10:0] COIN_20 = 11'd20;
  localparam logic [10:0] COIN_10 = 11'd10;
  localparam logic [10:0] COIN_5  = 11'd5;
  localparam logic [10:0] COIN_1  = 11'd1;

  // coins packs 4-bit counts: [3:0] 50s, [7:4] 20s, [11:8] 10s, [15:12] 5s, [19:16] 1s
  function automatic logic [10:0] change_sum(input logic [19:0] coins);
    return COIN_50 * {7'd0, coins[3:0]}   + COIN_20 * {7'd0, coins[7:4]} +
           COIN_10 * {7'd0, coins[11:8]}  + COIN_5  * {7'd0, coins[15:12]} +
           COIN_1  * {7'd0, coins[19:16]};
  endfunction
endpackage

// File: rtl/vm_host_if.sv
// Host command, vending-machine command/response and host response signals of vm_host.
// slave = vm_host view, master = host/vending-machine environment view.
interface vm_host_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [29:0] cmd_prices;
  logic [5:0]  cmd_coin;
  logic [2:0]  cmd_item;

  logic        in_price_valid;
  logic [4:0]  in_price;
  logic        in_coin_valid;
  logic [5:0]  in_coin;
  logic        in_refund_coin;
  logic [2:0]  in_buy_item;

  logic        out_valid;
  logic [3:0]  out_result;
  logic [5:0]  out_num;

  logic        rsp_valid;
  logic [3:0]  rsp_item;
  logic [19:0] rsp_coins;
  logic [35:0] rsp_nums;
  logic [10:0] rsp_change;
  logic        rsp_err;

  modport slave (
    input  cmd_valid, cmd_op, cmd_prices, cmd_coin, cmd_item,
    input  out_valid, out_result, out_num,
    output cmd_ready,
    output in_price_valid, in_price, in_coin_valid, in_coin, in_refund_coin, in_buy_item,
    output rsp_valid, rsp_item, rsp_coins, rsp_nums, rsp_change, rsp_err
  );

  modport master (
    output cmd_valid, cmd_op, cmd_prices, cmd_coin, cmd_item,
    output out_valid, out_result, out_num,
    input  cmd_ready,
    input  in_price_valid, in_price, in_coin_valid, in_coin, in_refund_coin, in_buy_item,
    input  rsp_valid, rsp_item, rsp_coins, rsp_nums, rsp_change, rsp_err
  );
endinterface

// File: rtl/vm_host_collect.sv
// Vending-machine reply capture: timeout counter, beat counter and capture registers.
// cap_* present the registered captures merged with the beat arriving this cycle (no latency).
module vm_host_collect #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        in_wait,
  input  logic        in_coll,
  input  logic        out_valid,
  input  logic [3:0]  out_result,
  input  logic [5:0]  out_num,
  output logic        wait_hit,
  output logic        wait_tmo,
  output logic        coll_done,
  output logic        coll_drop,
  output logic [3:0]  cap_item,
  output logic [19:0] cap_coins,
  output logic [35:0] cap_nums
);
  import vm_pkg::*;

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] tcnt;
  logic [2:0]    bcnt;
  logic [3:0]    item_q;
  logic [19:0]   coins_q;
  logic [35:0]   nums_q;
  logic          beat;

  assign beat      = in_coll && out_valid;
  assign wait_hit  = in_wait && out_valid;
  // tcnt is 1 on the first WAIT cycle, so it counts cycles since the buy/refund beat
  assign wait_tmo  = in_wait && !out_valid && (tcnt >= TLAST);
  assign coll_done = beat && (bcnt == 3'(NUM_ITEMS - 1));
  assign coll_drop = in_coll && !out_valid;

  always_comb begin
    cap_item  = item_q;
    cap_coins = coins_q;
    cap_nums  = nums_q;
    if (wait_hit) begin
      cap_item      = out_result;
      cap_nums[5:0] = out_num;
    end
    for (int k = 1; k < NUM_ITEMS; k++) begin
      if (beat && bcnt == 3'(k)) begin
        cap_coins[4*(k-1) +: 4] = out_result;
        cap_nums[6*k +: 6]      = out_num;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt    <= '0;
      bcnt    <= '0;
      item_q  <= '0;
      coins_q <= '0;
      nums_q  <= '0;
    end else if (start) begin
      tcnt    <= TW'(1);
      bcnt    <= '0;
      item_q  <= '0;
      coins_q <= '0;
      nums_q  <= '0;
    end else begin
      item_q  <= cap_item;
      coins_q <= cap_coins;
      nums_q  <= cap_nums;
      if (in_wait) tcnt <= tcnt + 1'b1;
      if (wait_hit) bcnt <= 3'd1;
      else if (beat) bcnt <= bcnt + 3'd1;
    end
  end
endmodule

// File: rtl/vm_host.sv
// vm_host: host command FSM driving a vending machine and returning its 6-beat reply; VM_HOST_CHANGE_SUM_EN adds rsp_change.
// Strobes 1 cycle after accept, rsp_valid 1 cycle after the last/failed beat; cmd_ready only while idle.
module vm_host #(
  parameter int TIMEOUT = 16
) (
  input logic      clk,
  input logic      rst_n,
  vm_host_if.slave bus
);
  import vm_pkg::*;

  state_t      state, state_nx;
  logic [29:0] prices_q;
  logic [2:0]  pidx;
  logic        accept;
  logic        wait_hit, wait_tmo, coll_done, coll_drop;
  logic [3:0]  cap_item;
  logic [19:0] cap_coins;
  logic [35:0] cap_nums;

  assign accept = bus.cmd_valid && bus.cmd_ready;

  vm_host_collect #(.TIMEOUT(TIMEOUT)) u_collect (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (state == S_CMD),
    .in_wait    (state == S_WAIT),
    .in_coll    (state == S_COLLECT),
    .out_valid  (bus.out_valid),
    .out_result (bus.out_result),
    .out_num    (bus.out_num),
    .wait_hit   (wait_hit),
    .wait_tmo   (wait_tmo),
    .coll_done  (coll_done),
    .coll_drop  (coll_drop),
    .cap_item   (cap_item),
    .cap_coins  (cap_coins),
    .cap_nums   (cap_nums)
  );

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          case (bus.cmd_op)
            OP_LOAD_PRICES: state_nx = S_PRICE;
            OP_COIN:        state_nx = S_COIN;
            default:        state_nx = S_CMD;
          endcase
        end
      end
      S_PRICE:   if (pidx == 3'(NUM_ITEMS - 1)) state_nx = S_IDLE;
      S_COIN:    state_nx = S_IDLE;
      S_CMD:     state_nx = S_WAIT;
      S_WAIT: begin
        if (wait_hit) state_nx = S_COLLECT;
        else if (wait_tmo) state_nx = S_RESP;
      end
      S_COLLECT: if (coll_done || coll_drop) state_nx = S_RESP;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= S_IDLE;
      prices_q           <= '0;
      pidx               <= '0;
      bus.cmd_ready      <= 1'b0;
      bus.in_price_valid <= 1'b0;
      bus.in_price       <= '0;
      bus.in_coin_valid  <= 1'b0;
      bus.in_coin        <= '0;
      bus.in_refund_coin <= 1'b0;
      bus.in_buy_item    <= '0;
      bus.rsp_valid      <= 1'b0;
      bus.rsp_item       <= '0;
      bus.rsp_coins      <= '0;
      bus.rsp_nums       <= '0;
      bus.rsp_err        <= 1'b0;
    end else begin
      state              <= state_nx;
      bus.cmd_ready      <= (state_nx == S_IDLE);
      bus.in_price_valid <= 1'b0;
      bus.in_price       <= '0;
      bus.in_coin_valid  <= 1'b0;
      bus.in_coin        <= '0;
      bus.in_refund_coin <= 1'b0;
      bus.in_buy_item    <= '0;
      bus.rsp_valid      <= 1'b0;
      if (accept) begin
        prices_q <= bus.cmd_prices;
        pidx     <= '0;
        case (bus.cmd_op)
          OP_LOAD_PRICES: begin
            bus.in_price_valid <= 1'b1;
            bus.in_price       <= bus.cmd_prices[4:0];
          end
          OP_COIN: begin
            bus.in_coin_valid <= 1'b1;
            bus.in_coin       <= bus.cmd_coin;
          end
          OP_BUY:  bus.in_buy_item    <= bus.cmd_item;
          default: bus.in_refund_coin <= 1'b1;
        endcase
      end
      // prices_q shifts down one item per beat; [9:5] is always the next price
      if (state == S_PRICE && pidx != 3'(NUM_ITEMS - 1)) begin
        pidx               <= pidx + 3'd1;
        prices_q           <= {5'd0, prices_q[29:5]};
        bus.in_price_valid <= 1'b1;
        bus.in_price       <= prices_q[9:5];
      end
      if (state_nx == S_RESP) begin
        bus.rsp_valid <= 1'b1;
        bus.rsp_item  <= cap_item;
        bus.rsp_coins <= cap_coins;
        bus.rsp_nums  <= cap_nums;
        bus.rsp_err   <= wait_tmo | coll_drop;
      end
    end
  end

`ifdef VM_HOST_CHANGE_SUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.rsp_change <= '0;
    else if (state_nx == S_RESP) bus.rsp_change <= change_sum(cap_coins);
  end
`else
  assign bus.rsp_change = '0;
`endif
endmodule

// File: tb/tb_vm_host.sv
// Self-checking bench for vm_host: scenario tasks with a response scoreboard queue.
module tb_vm_host;
  import vm_pkg::*;

  typedef struct packed {
    logic [3:0]  item;
    logic [19:0] coins;
    logic [35:0] nums;
    logic [10:0] change;
    logic        err;
  } rsp_t;

`ifdef VM_HOST_CHANGE_SUM_EN
  localparam bit SUM_EN = 1'b1;
`else
  localparam bit SUM_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  rsp_t exp_q[$];
  logic [4:0] price_q[$];

  vm_host_if bus();

  vm_host #(.TIMEOUT(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] exp_change(input logic [19:0] c);
    int s;
    s = 50 * c[3:0] + 20 * c[7:4] + 10 * c[11:8] + 5 * c[15:12] + c[19:16];
    return SUM_EN ? 11'(s) : 11'd0;
  endfunction

  task automatic clear_inputs;
    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_prices = '0; bus.cmd_coin = '0; bus.cmd_item = '0;
    bus.out_valid = 1'b0; bus.out_result = '0; bus.out_num = '0;
  endtask

  // Returns one ns after the accepting edge, i.e. inside the strobe cycle; fields are scrambled afterwards.
  task automatic send_cmd(input logic [1:0] op, input logic [29:0] prices, input logic [5:0] coin, input logic [2:0] item);
    int n = 0;
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_prices = prices; bus.cmd_coin = coin; bus.cmd_item = item;
    @(negedge clk);
    while (!bus.cmd_ready && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL send_cmd_ready: cmd_ready=%b after %0d cycles, required 1", bus.cmd_ready, n);
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0; bus.cmd_op = ~op; bus.cmd_prices = ~prices; bus.cmd_coin = ~coin; bus.cmd_item = ~item;
  endtask

  task automatic drive_beat(input logic [3:0] res, input logic [5:0] num);
    bus.out_valid = 1'b1; bus.out_result = res; bus.out_num = num;
    @(posedge clk); #1;
  endtask

  // n = negedges after the first one sampled before rsp_valid, -1 if it never came
  task automatic wait_rsp(input int limit, output int n);
    n = 0;
    @(negedge clk);
    while (!bus.rsp_valid && n < limit) begin @(negedge clk); n++; end
    if (!bus.rsp_valid) n = -1;
  endtask

  task automatic test_reset;
    clear_inputs();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.cmd_ready, bus.in_price_valid, bus.in_coin_valid, bus.in_refund_coin, bus.rsp_valid, bus.rsp_err} !== 6'b0) begin
      errors++; $display("FAIL reset_strobes: got %b required 000000",
        {bus.cmd_ready, bus.in_price_valid, bus.in_coin_valid, bus.in_refund_coin, bus.rsp_valid, bus.rsp_err});
    end
    checks++;
    if ({bus.in_price, bus.in_coin, bus.in_buy_item, bus.rsp_item, bus.rsp_coins, bus.rsp_nums, bus.rsp_change} !== 85'd0) begin
      errors++; $display("FAIL reset_data: got %h required 0",
        {bus.in_price, bus.in_coin, bus.in_buy_item, bus.rsp_item, bus.rsp_coins, bus.rsp_nums, bus.rsp_change});
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: cmd_ready=%b required 1", bus.cmd_ready);
    end
  endtask

  task automatic test_load_prices;
    logic [29:0] p = {5'd31, 5'd13, 5'd11, 5'd7, 5'd5, 5'd3};
    logic [4:0]  e;
    price_q.push_back(5'd3);  price_q.push_back(5'd5);  price_q.push_back(5'd7);
    price_q.push_back(5'd11); price_q.push_back(5'd13); price_q.push_back(5'd31);
    send_cmd(OP_LOAD_PRICES, p, 6'd0, 3'd0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if (bus.in_price_valid !== (k < 6)) begin
        errors++; $display("FAIL price_valid_%0d: got %b required %b", k, bus.in_price_valid, (k < 6));
      end
      if (bus.in_price_valid === 1'b1 && price_q.size() > 0) begin
        e = price_q.pop_front();
        checks++;
        if (bus.in_price !== e) begin
          errors++; $display("FAIL price_value_%0d: got %0d required %0d", k, bus.in_price, e);
        end
        checks++;
        if (bus.cmd_ready !== 1'b0) begin
          errors++; $display("FAIL price_ready_%0d: cmd_ready=%b required 0", k, bus.cmd_ready);
        end
      end else if (bus.in_price_valid !== 1'b1) begin
        checks++;
        if (bus.in_price !== 5'd0) begin
          errors++; $display("FAIL price_idle_zero_%0d: got %0d required 0", k, bus.in_price);
        end
      end
    end
    checks++;
    if (price_q.size() != 0) begin
      errors++; $display("FAIL price_count: %0d prices not seen, required 0", price_q.size());
    end
  endtask

  task automatic test_coin_buy;
    logic [3:0] res[6] = '{4'd2, 4'd1, 4'd1, 4'd1, 4'd1, 4'd0};
    logic [5:0] num[6] = '{6'd4, 6'd9, 6'd17, 6'd33, 6'd60, 6'd1};
    rsp_t e, got;
    int   n;
    send_cmd(OP_COIN, 30'd0, 6'd50, 3'd0);
    @(negedge clk);
    checks++;
    if ({bus.in_coin_valid, bus.in_coin} !== {1'b1, 6'd50}) begin
      errors++; $display("FAIL coin50: valid=%b coin=%0d required 1/50", bus.in_coin_valid, bus.in_coin);
    end
    @(negedge clk);
    checks++;
    if ({bus.in_coin_valid, bus.in_coin} !== 7'd0) begin
      errors++; $display("FAIL coin_clear: valid=%b coin=%0d required 0/0", bus.in_coin_valid, bus.in_coin);
    end
    send_cmd(OP_COIN, 30'd0, 6'd20, 3'd0);
    @(negedge clk);
    checks++;
    if ({bus.in_coin_valid, bus.in_coin} !== {1'b1, 6'd20}) begin
      errors++; $display("FAIL coin20: valid=%b coin=%0d required 1/20", bus.in_coin_valid, bus.in_coin);
    end
    e = '0;
    e.item   = 4'd2;
    e.coins  = 20'h01111;
    for (int k = 0; k < 6; k++) e.nums[6*k +: 6] = num[k];
    e.change = SUM_EN ? 11'd85 : 11'd0;
    exp_q.push_back(e);
    send_cmd(OP_BUY, 30'd0, 6'd0, 3'd2);
    @(negedge clk);
    checks++;
    if (bus.in_buy_item !== 3'd2) begin
      errors++; $display("FAIL buy_item: got %0d required 2", bus.in_buy_item);
    end
    @(posedge clk); #1;
    for (int k = 0; k < 6; k++) drive_beat(res[k], num[k]);
    clear_inputs();
    wait_rsp(40, n);
    checks++;
    if (n != 0) begin
      errors++; $display("FAIL buy_rsp_latency: rsp after %0d extra cycles, required 0", n);
    end
    got = {bus.rsp_item, bus.rsp_coins, bus.rsp_nums, bus.rsp_change, bus.rsp_err};
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin
      errors++; $display("FAIL buy_rsp: got %h required %h", got, e);
    end
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_item !== 4'd2) begin
      errors++; $display("FAIL buy_rsp_pulse_hold: valid=%b item=%0d required 0/2", bus.rsp_valid, bus.rsp_item);
    end
  endtask

  task automatic test_timeout;
    rsp_t e, got;
    int   n;
    e = '0;
    e.err = 1'b1;
    exp_q.push_back(e);
    send_cmd(OP_BUY, 30'd0, 6'd0, 3'd1);
    wait_rsp(40, n);
    checks++;
    if (n != 16) begin
      errors++; $display("FAIL timeout_latency: rsp %0d cycles after buy beat, required 16", n);
    end
    got = {bus.rsp_item, bus.rsp_coins, bus.rsp_nums, bus.rsp_change, bus.rsp_err};
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin
      errors++; $display("FAIL timeout_rsp: got %h required %h", got, e);
    end
  endtask

  task automatic test_refund_drop;
    rsp_t e, got;
    int   n;
    e = '0;
    e.coins  = 20'h00032;
    e.nums   = {18'd0, 6'd9, 6'd8, 6'd7};
    e.change = exp_change(e.coins);
    e.err    = 1'b1;
    exp_q.push_back(e);
    send_cmd(OP_REFUND, 30'd0, 6'd0, 3'd0);
    @(negedge clk);
    checks++;
    if ({bus.in_refund_coin, bus.in_buy_item} !== 4'b1000) begin
      errors++; $display("FAIL refund_strobe: refund=%b item=%0d required 1/0", bus.in_refund_coin, bus.in_buy_item);
    end
    @(posedge clk); #1;
    drive_beat(4'd0, 6'd7);
    drive_beat(4'd2, 6'd8);
    drive_beat(4'd3, 6'd9);
    clear_inputs();
    wait_rsp(40, n);
    checks++;
    if (n != 1) begin
      errors++; $display("FAIL drop_latency: rsp %0d cycles after drop, required 1", n);
    end
    got = {bus.rsp_item, bus.rsp_coins, bus.rsp_nums, bus.rsp_change, bus.rsp_err};
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin
      errors++; $display("FAIL drop_rsp: got %h required %h", got, e);
    end
  endtask

  task automatic test_held_valid;
    int  acc_k = -1, coin_k = -1, coin_cnt = 0;
    bit  drop;
    send_cmd(OP_LOAD_PRICES, {5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6}, 6'd0, 3'd0);
    bus.cmd_valid = 1'b1; bus.cmd_op = OP_COIN; bus.cmd_coin = 6'd7;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (bus.in_coin_valid === 1'b1) begin
        coin_cnt++; coin_k = k;
        checks++;
        if (bus.in_coin !== 6'd7) begin
          errors++; $display("FAIL held_coin_value: got %0d required 7", bus.in_coin);
        end
      end
      drop = bus.cmd_valid && bus.cmd_ready;
      if (drop) acc_k = k;
      @(posedge clk); #1;
      if (drop) bus.cmd_valid = 1'b0;
    end
    clear_inputs();
    checks++;
    if (acc_k != 6) begin
      errors++; $display("FAIL held_accept_cycle: accepted at %0d required 6", acc_k);
    end
    checks++;
    if (coin_cnt != 1 || coin_k != 7) begin
      errors++; $display("FAIL held_once: %0d coin strobes at %0d, required 1 at 7", coin_cnt, coin_k);
    end
  endtask

  task automatic test_reset_mid;
    logic [3:0] res[6] = '{4'd4, 4'd0, 4'd2, 4'd0, 4'd1, 4'd3};
    logic [5:0] num[6] = '{6'd11, 6'd22, 6'd33, 6'd44, 6'd55, 6'd63};
    rsp_t e, got;
    int   n, stray = 0;
    send_cmd(OP_BUY, 30'd0, 6'd0, 3'd3);
    @(posedge clk); #1;
    drive_beat(4'd3, 6'd1);
    drive_beat(4'd1, 6'd2);
    drive_beat(4'd1, 6'd3);
    bus.out_valid = 1'b1; bus.out_result = 4'd1; bus.out_num = 6'd4;
    #2 rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.cmd_ready, bus.in_price_valid, bus.in_coin_valid, bus.in_refund_coin, bus.rsp_valid, bus.rsp_err,
         bus.in_price, bus.in_coin, bus.in_buy_item, bus.rsp_item, bus.rsp_coins, bus.rsp_nums, bus.rsp_change} !== 91'd0) begin
      errors++; $display("FAIL midreset_outputs: got %h required 0",
        {bus.cmd_ready, bus.in_price_valid, bus.in_coin_valid, bus.in_refund_coin, bus.rsp_valid, bus.rsp_err,
         bus.in_price, bus.in_coin, bus.in_buy_item, bus.rsp_item, bus.rsp_coins, bus.rsp_nums, bus.rsp_change});
    end
    @(posedge clk); #1;
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++; $display("FAIL midreset_no_rsp: %0d rsp_valid cycles, required 0", stray);
    end
    e = '0;
    e.item   = 4'd4;
    e.coins  = 20'h31020;
    for (int k = 0; k < 6; k++) e.nums[6*k +: 6] = num[k];
    e.change = SUM_EN ? 11'd48 : 11'd0;
    exp_q.push_back(e);
    send_cmd(OP_BUY, 30'd0, 6'd0, 3'd4);
    @(negedge clk);
    checks++;
    if (bus.in_buy_item !== 3'd4) begin
      errors++; $display("FAIL after_reset_buy_item: got %0d required 4", bus.in_buy_item);
    end
    @(posedge clk); #1;
    for (int k = 0; k < 6; k++) drive_beat(res[k], num[k]);
    clear_inputs();
    wait_rsp(40, n);
    checks++;
    if (n != 0) begin
      errors++; $display("FAIL after_reset_latency: rsp after %0d extra cycles, required 0", n);
    end
    got = {bus.rsp_item, bus.rsp_coins, bus.rsp_nums, bus.rsp_change, bus.rsp_err};
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin
      errors++; $display("FAIL after_reset_rsp: got %h required %h", got, e);
    end
  endtask

  initial begin
    test_reset();
    test_load_prices();
    test_coin_buy();
    test_timeout();
    test_refund_drop();
    test_held_valid();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at 100000 ns, required to finish earlier");
    $fatal(1, "watchdog expired");
  end
endmodule
